// File: rtl/tlp_tx_arbiter.sv
// tlp_tx_arbiter: packet-level round-robin arbiter moving whole TLPs from two
// FWFT staging FIFOs into the single PCIe master FIFO. Words are 18 bits:
// bit17 = SOP, bit16 = EOP, [15:0] = payload.
// Optional build macro ARB_PKT_STATS_EN adds per-port EOP packet counters.
module tlp_tx_arbiter #(
    parameter int NREQ   = 2,
    parameter int WORD_W = 18
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              arb_en,
    input  logic [WORD_W-1:0] req0_dout,
    input  logic              req0_empty,
    output logic              req0_rd_en,
    input  logic [WORD_W-1:0] req1_dout,
    input  logic              req1_empty,
    output logic              req1_rd_en,
    output logic [WORD_W-1:0] mst_din,
    input  logic              mst_full,
    output logic              mst_wr_en,
    output logic [NREQ-1:0]   grant,
    output logic [7:0]        drop_cnt
`ifdef ARB_PKT_STATS_EN
   ,output logic [15:0]       pkt_cnt0,
    output logic [15:0]       pkt_cnt1
`endif
);

    localparam int SOP = WORD_W - 1;
    localparam int EOP = WORD_W - 2;

    typedef enum logic [1:0] {ARB_IDLE, ARB_P0, ARB_P1} state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic [7:0]        drop_q, drop_d;
    logic [WORD_W-1:0] din_q, din_d;
    logic              wr_q, wr_d;
    logic              rd0, rd1;
    logic              eop_pop0, eop_pop1;
    logic              cand0, cand1;

    // A port may win arbitration only when its head word opens a packet.
    assign cand0 = !req0_empty && req0_dout[SOP];
    assign cand1 = !req1_empty && req1_dout[SOP];

    // State register and registered master-FIFO write port.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= ARB_IDLE;
            last_q  <= 1'b1;
            drop_q  <= 8'd0;
            din_q   <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            drop_q  <= drop_d;
            din_q   <= din_d;
            wr_q    <= wr_d;
        end
    end

    // Grant/drop decision in idle, word forwarding while a packet is owned.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        drop_d   = drop_q;
        din_d    = din_q;
        wr_d     = 1'b0;
        rd0      = 1'b0;
        rd1      = 1'b0;
        eop_pop0 = 1'b0;
        eop_pop1 = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (arb_en && (cand0 || cand1)) begin
                    // On a tie the port that did not send last wins.
                    if (cand0 && (!cand1 || last_q)) state_d = ARB_P0;
                    else                             state_d = ARB_P1;
                end else if (!req0_empty && !req0_dout[SOP]) begin
                    rd0 = 1'b1;
                    if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                end else if (!req1_empty && !req1_dout[SOP]) begin
                    rd1 = 1'b1;
                    if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                end
            end
            ARB_P0: begin
                if (!req0_empty && !mst_full) begin
                    rd0   = 1'b1;
                    wr_d  = 1'b1;
                    din_d = req0_dout;
                    if (req0_dout[EOP]) begin
                        eop_pop0 = 1'b1;
                        state_d  = ARB_IDLE;
                        last_d   = 1'b0;
                    end
                end
            end
            ARB_P1: begin
                if (!req1_empty && !mst_full) begin
                    rd1   = 1'b1;
                    wr_d  = 1'b1;
                    din_d = req1_dout;
                    if (req1_dout[EOP]) begin
                        eop_pop1 = 1'b1;
                        state_d  = ARB_IDLE;
                        last_d   = 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign req0_rd_en = rd0;
    assign req1_rd_en = rd1;
    assign mst_din    = din_q;
    assign mst_wr_en  = wr_q;
    assign drop_cnt   = drop_q;
    assign grant      = {state_q == ARB_P1, state_q == ARB_P0};

`ifdef ARB_PKT_STATS_EN
    logic [15:0] pkt0_q, pkt1_q;

    // Completed-packet counters, wrapping, bumped on each EOP pop.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pkt0_q <= 16'd0;
            pkt1_q <= 16'd0;
        end else begin
            if (eop_pop0) pkt0_q <= pkt0_q + 16'd1;
            if (eop_pop1) pkt1_q <= pkt1_q + 16'd1;
        end
    end

    assign pkt_cnt0 = pkt0_q;
    assign pkt_cnt1 = pkt1_q;
`endif

endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// Bench for tlp_tx_arbiter: IDLE-decision vector table, directed multi-cycle
// sequences and random traffic checked against a packet-level reference model.
module tb_tlp_tx_arbiter;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        arb_en = 1'b0;
    logic [17:0] req0_dout = '0, req1_dout = '0;
    logic        req0_empty = 1'b1, req1_empty = 1'b1;
    logic        req0_rd_en, req1_rd_en;
    logic [17:0] mst_din;
    logic        mst_full = 1'b0;
    logic        mst_wr_en;
    logic [1:0]  grant;
    logic [7:0]  drop_cnt;
`ifdef ARB_PKT_STATS_EN
    logic [15:0] pkt_cnt0, pkt_cnt1;
`endif

    tlp_tx_arbiter dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .arb_en(arb_en),
        .req0_dout(req0_dout), .req0_empty(req0_empty), .req0_rd_en(req0_rd_en),
        .req1_dout(req1_dout), .req1_empty(req1_empty), .req1_rd_en(req1_rd_en),
        .mst_din(mst_din), .mst_full(mst_full), .mst_wr_en(mst_wr_en),
        .grant(grant), .drop_cnt(drop_cnt)
`ifdef ARB_PKT_STATS_EN
       ,.pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    int vecs = 0;
    int errs = 0;

    // Staging FIFO contents, master FIFO write log, stimulus controls.
    logic [17:0] q0[$], q1[$], wlog[$], expq[$];
    logic        tb_en, tb_full;

    // Reference model: owner (-1 idle), last sender, drops, expected write.
    int          m_own;
    bit          m_last;
    int          m_drop;
    bit          m_wr;
    logic [17:0] m_din;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] word_of(input int len, input logic [7:0] tag, input int i);
        logic [7:0] idx;
        idx = i[7:0];
        return {(i == 0), (i == len - 1), tag, idx};
    endfunction

    task automatic push_pkt(input int port, input int len, input logic [7:0] tag);
        for (int i = 0; i < len; i++) begin
            if (port == 0) q0.push_back(word_of(len, tag, i));
            else           q1.push_back(word_of(len, tag, i));
        end
    endtask

    task automatic model_reset();
        m_own = -1; m_last = 1'b1; m_drop = 0; m_wr = 1'b0; m_din = '0;
    endtask

    // Called just after a falling edge: reset DUT and model, clear FIFOs.
    task automatic apply_reset();
        q0.delete(); q1.delete(); wlog.delete();
        req0_empty = 1'b1; req1_empty = 1'b1;
        sys_rst = 1'b1;
        #2 sys_rst = 1'b0;
        model_reset();
    endtask

    // One clock of FIFO-fed operation with full per-cycle model comparison.
    task automatic cycle();
        logic [17:0] h0, h1, head;
        bit ne0, ne1, c0, c1, x0, x1, a0, a1, ne;
        ne0 = q0.size() != 0; h0 = ne0 ? q0[0] : 18'h0;
        ne1 = q1.size() != 0; h1 = ne1 ? q1[0] : 18'h0;
        req0_empty = !ne0; req0_dout = h0;
        req1_empty = !ne1; req1_dout = h1;
        arb_en = tb_en; mst_full = tb_full;
        #1;
        check("grant", {30'd0, grant}, m_own == 0 ? 2 'b01 : m_own == 1 ? 2'b10 : 2'b00);
        check("mst_wr_en", {31'd0, mst_wr_en}, {31'd0, m_wr});
        check("mst_din", {14'd0, mst_din}, {14'd0, m_din});
        check("drop_cnt", {24'd0, drop_cnt}, m_drop);
        if (mst_wr_en) wlog.push_back(mst_din);
        x0 = 0; x1 = 0; m_wr = 1'b0;
        if (m_own < 0) begin
            c0 = ne0 && h0[17]; c1 = ne1 && h1[17];
            if (tb_en && (c0 || c1)) begin
                if (c0 && c1) m_own = m_last ? 0 : 1;
                else          m_own = c0 ? 0 : 1;
            end else if (ne0 && !h0[17]) begin
                x0 = 1; if (m_drop < 255) m_drop++;
            end else if (ne1 && !h1[17]) begin
                x1 = 1; if (m_drop < 255) m_drop++;
            end
        end else begin
            ne = (m_own == 0) ? ne0 : ne1;
            head = (m_own == 0) ? h0 : h1;
            if (ne && !tb_full) begin
                if (m_own == 0) x0 = 1; else x1 = 1;
                m_wr = 1'b1; m_din = head;
                if (head[16]) begin m_last = (m_own == 1); m_own = -1; end
            end
        end
        a0 = req0_rd_en; a1 = req1_rd_en;
        check("rd_en", {30'd0, a1, a0}, {30'd0, x1, x0});
        @(posedge sys_clk);
        #1;
        if (a0 && q0.size() != 0) void'(q0.pop_front());
        if (a1 && q1.size() != 0) void'(q1.pop_front());
        @(negedge sys_clk);
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || m_own >= 0 || m_wr) && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) check({name, "_timeout"}, n, 0);
    endtask

    task automatic check_log(input string name);
        check({name, "_len"}, wlog.size(), expq.size());
        for (int i = 0; i < expq.size() && i < wlog.size(); i++)
            check({name, "_word"}, {14'd0, wlog[i]}, {14'd0, expq[i]});
    endtask

    typedef struct {
        logic        en;
        logic        e0;
        logic [17:0] d0;
        logic        e1;
        logic [17:0] d1;
        logic [1:0]  rd;
        logic [1:0]  gnt;
        logic [7:0]  drop;
    } vec_t;

    vec_t vt[10];

    initial begin
        // IDLE decisions straight out of reset (last = 1, so port 0 wins ties).
        vt[0] = '{1, 0, 18'h2_0001, 1, 18'h0_0000, 2'b00, 2'b01, 8'd0};
        vt[1] = '{1, 0, 18'h2_0001, 0, 18'h2_0002, 2'b00, 2'b01, 8'd0};
        vt[2] = '{1, 1, 18'h2_0001, 0, 18'h2_0002, 2'b00, 2'b10, 8'd0};
        vt[3] = '{0, 0, 18'h2_0001, 0, 18'h2_0002, 2'b00, 2'b00, 8'd0};
        vt[4] = '{0, 0, 18'h0_0ABC, 1, 18'h0_0000, 2'b01, 2'b00, 8'd1};
        vt[5] = '{1, 0, 18'h0_0ABC, 0, 18'h2_0002, 2'b00, 2'b10, 8'd0};
        vt[6] = '{1, 0, 18'h1_0ABC, 0, 18'h0_0DEF, 2'b01, 2'b00, 8'd1};
        vt[7] = '{0, 1, 18'h0_0ABC, 0, 18'h0_0DEF, 2'b10, 2'b00, 8'd1};
        vt[8] = '{1, 1, 18'h0_0000, 1, 18'h0_0000, 2'b00, 2'b00, 8'd0};
        vt[9] = '{1, 1, 18'h2_0001, 0, 18'h3_0002, 2'b00, 2'b10, 8'd0};

        tb_en = 1'b1; tb_full = 1'b0;
        model_reset();
        @(negedge sys_clk);
        apply_reset();
        #1;
        check("rst_grant", {30'd0, grant}, 0);
        check("rst_wr_en", {31'd0, mst_wr_en}, 0);
        check("rst_din", {14'd0, mst_din}, 0);
        check("rst_drop", {24'd0, drop_cnt}, 0);
        @(negedge sys_clk);

        for (int v = 0; v < 10; v++) begin
            apply_reset();
            arb_en = vt[v].en; mst_full = 1'b0;
            req0_empty = vt[v].e0; req0_dout = vt[v].d0;
            req1_empty = vt[v].e1; req1_dout = vt[v].d1;
            #1;
            check("vec_rd", {30'd0, req1_rd_en, req0_rd_en}, {30'd0, vt[v].rd});
            @(posedge sys_clk);
            #1;
            check("vec_grant", {30'd0, grant}, {30'd0, vt[v].gnt});
            check("vec_drop", {24'd0, drop_cnt}, {24'd0, vt[v].drop});
            @(negedge sys_clk);
        end

        // 35-word packet from requester 0.
        apply_reset();
        q0.push_back(18'h2_90FF);
        for (int i = 1; i < 34; i++) q0.push_back({2'b00, 16'(i)});
        q0.push_back(18'h1_1234);
        expq = q0;
        run_until_idle("long", 100);
        check_log("long");
        check("long_last", {14'd0, mst_din}, 32'h1_1234);

        // Both ports with two 3-word packets: P0, P1, P0, P1.
        apply_reset();
        push_pkt(0, 3, 8'h00); push_pkt(0, 3, 8'h01);
        push_pkt(1, 3, 8'h10); push_pkt(1, 3, 8'h11);
        expq.delete();
        for (int i = 0; i < 3; i++) expq.push_back(word_of(3, 8'h00, i));
        for (int i = 0; i < 3; i++) expq.push_back(word_of(3, 8'h10, i));
        for (int i = 0; i < 3; i++) expq.push_back(word_of(3, 8'h01, i));
        for (int i = 0; i < 3; i++) expq.push_back(word_of(3, 8'h11, i));
        run_until_idle("rr", 100);
        check_log("rr");

        // mst_full held for 5 cycles mid-packet.
        apply_reset();
        push_pkt(0, 8, 8'h20);
        expq = q0;
        for (int i = 0; i < 4; i++) cycle();
        tb_full = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        tb_full = 1'b0;
        run_until_idle("full", 50);
        check_log("full");

        // Leading word without SOP on requester 1 is dropped.
        apply_reset();
        q1.push_back(18'h0_0ABC);
        push_pkt(1, 4, 8'h30);
        expq.delete();
        for (int i = 0; i < 4; i++) expq.push_back(word_of(4, 8'h30, i));
        run_until_idle("drop", 50);
        check("drop_one", {24'd0, drop_cnt}, 1);
        check_log("drop");

        // arb_en falls during word 3 of a 10-word packet.
        apply_reset();
        push_pkt(0, 10, 8'h40); push_pkt(0, 3, 8'h41); push_pkt(1, 3, 8'h50);
        expq.delete();
        for (int i = 0; i < 10; i++) expq.push_back(word_of(10, 8'h40, i));
        for (int i = 0; i < 40; i++) begin
            if (q0.size() <= 10) tb_en = 1'b0;
            cycle();
        end
        check_log("en_off");
        check("en_off_grant", {30'd0, grant}, 0);
        check("en_off_q0", q0.size(), 3);
        check("en_off_q1", q1.size(), 3);
        tb_en = 1'b1;

        // Asynchronous reset mid-packet.
        apply_reset();
        push_pkt(0, 8, 8'h60);
        for (int i = 0; i < 4; i++) cycle();
        #2 sys_rst = 1'b1;
        #1;
        check("midrst_grant", {30'd0, grant}, 0);
        check("midrst_wr_en", {31'd0, mst_wr_en}, 0);
        q0.delete(); q1.delete(); wlog.delete();
        req0_empty = 1'b1; req1_empty = 1'b1;
        model_reset();
        #1 sys_rst = 1'b0;
        @(negedge sys_clk);
        push_pkt(1, 2, 8'h71); push_pkt(0, 2, 8'h70);
        cycle();
        check("midrst_first", {30'd0, grant}, 2'b01);
        run_until_idle("midrst", 50);
        check("midrst_word0", {14'd0, wlog[0]}, {14'd0, word_of(2, 8'h70, 0)});

        // Random traffic with random back-pressure and enable.
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            if (q0.size() < 4 && $urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 9) == 0) q0.push_back({2'b00, 16'($urandom)});
                push_pkt(0, $urandom_range(1, 6), 8'($urandom));
            end
            if (q1.size() < 4 && $urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 9) == 0) q1.push_back({2'b01, 16'($urandom)});
                push_pkt(1, $urandom_range(1, 6), 8'($urandom));
            end
            tb_full = ($urandom_range(0, 3) == 0);
            tb_en   = ($urandom_range(0, 7) != 0);
            cycle();
        end
        tb_en = 1'b1; tb_full = 1'b0;
        run_until_idle("rand", 200);

        // drop_cnt saturates at 8'hFF.
        apply_reset();
        tb_en = 1'b0;
        for (int i = 0; i < 260; i++) q1.push_back({2'b00, 16'(i)});
        run_until_idle("sat", 400);
        check("drop_sat", {24'd0, drop_cnt}, 32'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
